// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle add/sub/logic/shift ops plus iterative
// radix-2 shift-add multiply and restoring divide on operand magnitudes.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iStart,
  input  logic [3:0]       iCtrl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oC_hi,
  output logic [WIDTH-1:0] oC_lo,
  output logic             oZero,
  output logic             oNeg,
  output logic             oOverflow,
  output logic             oDivZero,
  output logic             oBusy,
  output logic             oDone
);

  localparam int M = WIDTH - 1;

  localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
  localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
  localparam logic [3:0] CTRL_ALU_OR  = 4'd2;
  localparam logic [3:0] CTRL_ALU_XOR = 4'd3;
  localparam logic [3:0] CTRL_ALU_AND = 4'd4;
  localparam logic [3:0] CTRL_ALU_MUL = 4'd5;
  localparam logic [3:0] CTRL_ALU_DIV = 4'd6;
  localparam logic [3:0] CTRL_ALU_SLL = 4'd7;
  localparam logic [3:0] CTRL_ALU_SRL = 4'd8;
  localparam logic [3:0] CTRL_ALU_SRA = 4'd9;
  localparam logic [3:0] CTRL_ALU_ROR = 4'd10;
  localparam logic [3:0] CTRL_ALU_ROL = 4'd11;
  localparam logic [3:0] CTRL_ALU_NOT = 4'd12;
  localparam logic [3:0] CTRL_ALU_NEG = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               op_mul_q, op_mul_d;
  logic               dz_q, dz_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, divz_q, divz_d;

  logic               accept, is_mul, is_div, is_iter, b_zero;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   abs_a, abs_b, add_sum, sub_dif, neg_res;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;

  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] div_sh, mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign accept  = iStart && (state_q == S_IDLE || state_q == S_DONE);
  assign is_mul  = (iCtrl == CTRL_ALU_MUL);
  assign is_div  = (iCtrl == CTRL_ALU_DIV);
  assign is_iter = is_mul || is_div;
  assign b_zero  = (iB == '0);

  assign sh      = iB[SHW-1:0];
  assign abs_a   = iA[M] ? ('0 - iA) : iA;
  assign abs_b   = iB[M] ? ('0 - iB) : iB;
  assign add_sum = iA + iB;
  assign sub_dif = iA - iB;
  assign neg_res = '0 - iA;
  // Rotates fall out of shifting a doubled copy of A.
  assign rot_r   = {iA, iA} >> sh;
  assign rot_l   = {iA, iA} << sh;

  // Single-cycle result path, evaluated straight from the input operands.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    sc_res = '0;
    sc_ovf = 1'b0;
    unique case (iCtrl)
      CTRL_ALU_ADD: begin
        sc_res = add_sum;
        sc_ovf = (iA[M] == iB[M]) && (add_sum[M] != iA[M]);
      end
      CTRL_ALU_SUB: begin
        sc_res = sub_dif;
        sc_ovf = (iA[M] != iB[M]) && (sub_dif[M] != iA[M]);
      end
      CTRL_ALU_NEG: begin
        sc_res = neg_res;
        sc_ovf = iA[M] && neg_res[M];
      end
      CTRL_ALU_OR:  sc_res = iA | iB;
      CTRL_ALU_XOR: sc_res = iA ^ iB;
      CTRL_ALU_AND: sc_res = iA & iB;
      CTRL_ALU_NOT: sc_res = ~iA;
      CTRL_ALU_SLL: sc_res = iA << sh;
      CTRL_ALU_SRL: sc_res = iA >> sh;
      CTRL_ALU_SRA: sc_res = $signed(iA) >>> sh;
      CTRL_ALU_ROR: sc_res = rot_r[WIDTH-1:0];
      CTRL_ALU_ROL: sc_res = rot_l[2*WIDTH-1:WIDTH];
      default:      sc_res = '0;
    endcase
  end

  // One iteration of each radix-2 datapath.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh    = {acc_q[2*WIDTH-2:0], 1'b0};
  assign div_trial = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, mag_q};
  assign div_next  = div_trial[WIDTH] ? div_sh
                                      : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

  assign prod = sign_q  ? ('0 - acc_q) : acc_q;
  assign quo  = sign_q  ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem  = rsign_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every flop, including the accumulators, is reset so an abandoned op leaves no residue.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      dz_q     <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      a_q      <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
      dz_q     <= dz_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      a_q      <= a_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      divz_q   <= divz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (!accept)                state_d = S_IDLE;
        else if (is_div && b_zero)  state_d = S_FIX;
        else if (is_iter)           state_d = S_ITER;
        else                        state_d = S_DONE;
      end
      S_ITER:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
    dz_d     = dz_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    a_d      = a_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    divz_d   = divz_q;

    if (accept && is_iter) begin
      op_mul_d = is_mul;
      dz_d     = is_div && b_zero;
      sign_d   = iA[M] ^ iB[M];
      rsign_d  = iA[M];
      a_d      = iA;
      cnt_d    = SHW'(WIDTH - 1);
      // MUL shifts the multiplier out of the low half; DIV shifts the dividend in.
      mag_d    = is_mul ? abs_a : abs_b;
      acc_d    = {{WIDTH{1'b0}}, (is_mul ? abs_b : abs_a)};
    end else if (accept) begin
      hi_d   = '0;
      lo_d   = sc_res;
      zero_d = (sc_res == '0);
      neg_d  = sc_res[M] ^ sc_ovf;
      ovf_d  = sc_ovf;
      divz_d = 1'b0;
    end else if (state_q == S_ITER) begin
      cnt_d = cnt_q - 1'b1;
      acc_d = op_mul_q ? mul_next : div_next;
    end else if (state_q == S_FIX) begin
      ovf_d = 1'b0;
      if (dz_q) begin
        hi_d   = a_q;
        lo_d   = '1;
        zero_d = 1'b0;
        neg_d  = 1'b0;
        divz_d = 1'b1;
      end else if (op_mul_q) begin
        hi_d   = prod[2*WIDTH-1:WIDTH];
        lo_d   = prod[WIDTH-1:0];
        zero_d = (prod == '0);
        neg_d  = prod[2*WIDTH-1];
        divz_d = 1'b0;
      end else begin
        hi_d   = rem;
        lo_d   = quo;
        zero_d = (rem == '0) && (quo == '0);
        neg_d  = sign_q;
        divz_d = 1'b0;
      end
    end
  end

  always_comb begin
    oBusy = (state_q == S_ITER) || (state_q == S_FIX);
    oDone = (state_q == S_DONE);
  end

  assign oC_hi     = hi_q;
  assign oC_lo     = lo_q;
  assign oZero     = zero_q;
  assign oNeg      = neg_q;
  assign oOverflow = ovf_q;
  assign oDivZero  = divz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, multicycle corner
// sequences, and random operations against a signed-arithmetic reference model.
module tb_seq_alu;

  localparam logic [3:0] C_ADD = 4'd0,  C_SUB = 4'd1,  C_OR  = 4'd2,  C_XOR = 4'd3;
  localparam logic [3:0] C_AND = 4'd4,  C_MUL = 4'd5,  C_DIV = 4'd6,  C_SLL = 4'd7;
  localparam logic [3:0] C_SRL = 4'd8,  C_SRA = 4'd9,  C_ROR = 4'd10, C_ROL = 4'd11;
  localparam logic [3:0] C_NOT = 4'd12, C_NEG = 4'd13, C_BAD = 4'd15;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero, neg, ovf, dz, busy1;
    int          lat;
  } res_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  logic        iStart;
  logic [3:0]  iCtrl;
  logic [31:0] iA, iB, oC_hi, oC_lo;
  logic        oZero, oNeg, oOverflow, oDivZero, oBusy, oDone;

  logic        s8;
  logic [3:0]  c8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        z8, n8, v8, dz8, busy8, done8;

  seq_alu #(.WIDTH(32)) dut (
    .iClk(clk), .nRst(nRst), .iStart(iStart), .iCtrl(iCtrl), .iA(iA), .iB(iB),
    .oC_hi(oC_hi), .oC_lo(oC_lo), .oZero(oZero), .oNeg(oNeg), .oOverflow(oOverflow),
    .oDivZero(oDivZero), .oBusy(oBusy), .oDone(oDone)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .iClk(clk), .nRst(nRst), .iStart(s8), .iCtrl(c8), .iA(a8), .iB(b8),
    .oC_hi(hi8), .oC_lo(lo8), .oZero(z8), .oNeg(n8), .oOverflow(v8),
    .oDivZero(dz8), .oBusy(busy8), .oDone(done8)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic on the operand values.
  function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    res_t        m;
    longint      sa, sb, r;
    logic [63:0] t, u;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = {32'h0, a};
    n  = int'(b[4:0]);
    m.hi = '0; m.lo = '0; m.ovf = 1'b0; m.dz = 1'b0; m.lat = 1;
    m.neg = 1'b0;
    case (c)
      C_ADD, C_SUB, C_NEG: begin
        r = (c == C_ADD) ? sa + sb : (c == C_SUB) ? sa - sb : -sa;
        u = r;
        m.lo  = u[31:0];
        m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.neg = (r < 0);
      end
      C_MUL: begin
        r = sa * sb;
        u = r;
        {m.hi, m.lo} = u;
        m.neg = (r < 0);
        m.lat = 34;
      end
      C_DIV: begin
        if (b == 0) begin
          m.hi = a; m.lo = '1; m.dz = 1'b1; m.lat = 2;
        end else begin
          u = sa / sb; m.lo = u[31:0];
          u = sa % sb; m.hi = u[31:0];
          m.neg = (sa < 0) != (sb < 0);
          m.lat = 34;
        end
      end
      default: begin
        case (c)
          C_OR:  m.lo = a | b;
          C_XOR: m.lo = a ^ b;
          C_AND: m.lo = a & b;
          C_NOT: m.lo = ~a;
          C_SLL: m.lo = a << n;
          C_SRL: m.lo = a >> n;
          C_SRA: begin r = sa >>> n; u = r; m.lo = u[31:0]; end
          C_ROR: begin u = (t >> n) | (t << (32 - n)); m.lo = u[31:0]; end
          C_ROL: begin u = (t << n) | (t >> (32 - n)); m.lo = u[31:0]; end
          default: m.lo = '0;
        endcase
        m.neg = m.lo[31];
      end
    endcase
    m.zero  = ({m.hi, m.lo} == 64'h0);
    m.busy1 = (m.lat > 1);
    return m;
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic [3:0] fl, input int lat);
    vec_t v;
    v.c = c; v.a = a; v.b = b;
    v.exp.hi = hi; v.exp.lo = lo;
    {v.exp.zero, v.exp.neg, v.exp.ovf, v.exp.dz} = fl;
    v.exp.lat = lat;
    v.exp.busy1 = (lat > 1);
    return v;
  endfunction

  // Launch one op; operands are scrambled after the start edge. poke>0 pulses
  // a stray ADD start in that busy cycle.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output res_t r, output logic done_at_start);
    int cyc;
    @(negedge clk);
    done_at_start = oDone;
    iStart = 1'b1; iCtrl = c; iA = a; iB = b;
    @(posedge clk); #1;
    iStart = 1'b0; iCtrl = 4'($urandom); iA = $urandom; iB = $urandom;
    cyc = 1;
    r.busy1 = oBusy;
    while (!oDone && cyc < 100) begin
      if (cyc == poke) begin
        iStart = 1'b1; iCtrl = C_ADD; iA = 32'd1; iB = 32'd1;
      end
      @(posedge clk); #1;
      iStart = 1'b0;
      cyc++;
    end
    r.hi = oC_hi; r.lo = oC_lo;
    r.zero = oZero; r.neg = oNeg; r.ovf = oOverflow; r.dz = oDivZero;
    r.lat = cyc;
  endtask

  task automatic compare_res(input string tag, input res_t got, input res_t exp);
    check({tag, ".latency"}, 64'(got.lat), 64'(exp.lat));
    check({tag, ".hi_lo"}, {got.hi, got.lo}, {exp.hi, exp.lo});
    check({tag, ".flags_zn_vd_busy"},
          64'({got.zero, got.neg, got.ovf, got.dz, got.busy1}),
          64'({exp.zero, exp.neg, exp.ovf, exp.dz, exp.busy1}));
  endtask

  task automatic run8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] hl, output logic neg, output int lat);
    @(negedge clk);
    s8 = 1'b1; c8 = c; a8 = a; b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hl = {hi8, lo8}; neg = n8;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    res_t        got, exp;
    logic        das, neg8, done_seen;
    logic [15:0] hl8;
    int          lat8;
    logic [3:0]  c;
    logic [31:0] a, b;

    vecs.push_back(mk(C_MUL, 32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 4'b0100, 34));
    vecs.push_back(mk(C_MUL, 32'h0,         32'h1234_5678, 32'h0,         32'h0,         4'b1000, 34));
    vecs.push_back(mk(C_DIV, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0100, 34));
    vecs.push_back(mk(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 4'b0000, 34));
    vecs.push_back(mk(C_DIV, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 4'b0100, 34));
    vecs.push_back(mk(C_DIV, 32'h9,         32'h0,         32'h9,         32'hFFFF_FFFF, 4'b0001, 2));
    vecs.push_back(mk(C_ADD, 32'h7FFF_FFFF, 32'h1,         32'h0,         32'h8000_0000, 4'b0010, 1));
    vecs.push_back(mk(C_SUB, 32'h5,         32'h5,         32'h0,         32'h0,         4'b1000, 1));
    vecs.push_back(mk(C_SUB, 32'h8000_0000, 32'h1,         32'h0,         32'h7FFF_FFFF, 4'b0110, 1));
    vecs.push_back(mk(C_NEG, 32'h8000_0000, 32'h0,         32'h0,         32'h8000_0000, 4'b0010, 1));
    vecs.push_back(mk(C_SRA, 32'h8000_0000, 32'd31,        32'h0,         32'hFFFF_FFFF, 4'b0100, 1));
    vecs.push_back(mk(C_ROL, 32'h8000_0001, 32'd1,         32'h0,         32'h0000_0003, 4'b0000, 1));
    vecs.push_back(mk(C_ROR, 32'h1234_5678, 32'd0,         32'h0,         32'h1234_5678, 4'b0000, 1));
    vecs.push_back(mk(C_SLL, 32'h1,         32'h21,        32'h0,         32'h2,         4'b0000, 1));
    vecs.push_back(mk(C_BAD, 32'hDEAD_BEEF, 32'h1,         32'h0,         32'h0,         4'b1000, 1));

    iStart = 1'b0; iCtrl = '0; iA = '0; iB = '0;
    s8 = 1'b0; c8 = '0; a8 = '0; b8 = '0;
    nRst = 1'b0;
    #12;
    check("reset.hi_lo", {oC_hi, oC_lo}, 64'h0);
    check("reset.flags", 64'({oZero, oNeg, oOverflow, oDivZero, oBusy, oDone}), 64'h0);
    @(negedge clk); nRst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, 0, got, das);
      compare_res($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Reset asserted mid-MUL: everything clears and no done pulse follows.
    run_op(C_ADD, 32'h7FFF_FFFF, 32'h1, 0, got, das);
    @(negedge clk);
    iStart = 1'b1; iCtrl = C_MUL; iA = 32'd7; iB = 32'd9;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (9) @(posedge clk);
    #1 nRst = 1'b0;
    #1;
    check("midmul_reset.hi_lo", {oC_hi, oC_lo}, 64'h0);
    check("midmul_reset.flags", 64'({oZero, oNeg, oOverflow, oDivZero, oBusy, oDone}), 64'h0);
    @(negedge clk); nRst = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (oDone) done_seen = 1'b1;
    end
    check("midmul_reset.no_done", 64'(done_seen), 64'h0);
    run_op(C_ADD, 32'd5, 32'd3, 0, got, das);
    compare_res("after_reset_add", got, mk(C_ADD, 0, 0, 32'h0, 32'h8, 4'b0000, 1).exp);

    // Stray start during a busy DIV is dropped; a start in DONE is taken.
    run_op(C_DIV, 32'd100, 32'd7, 5, got, das);
    compare_res("div_busy_poke", got, mk(C_DIV, 0, 0, 32'd2, 32'd14, 4'b0000, 34).exp);
    run_op(C_ADD, 32'd2, 32'd2, 0, got, das);
    check("b2b.started_in_done", 64'(das), 64'h1);
    compare_res("b2b_add", got, mk(C_ADD, 0, 0, 32'h0, 32'h4, 4'b0000, 1).exp);

    run8(C_MUL, 8'h80, 8'h80, hl8, neg8, lat8);
    check("w8_mul.latency", 64'(lat8), 64'd10);
    check("w8_mul.hi_lo", 64'(hl8), 64'h4000);
    check("w8_mul.neg", 64'(neg8), 64'h0);
    run8(C_DIV, 8'h80, 8'hFF, hl8, neg8, lat8);
    check("w8_div.latency", 64'(lat8), 64'd10);
    check("w8_div.hi_lo", 64'(hl8), 64'h0080);

    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      exp = model(c, a, b);
      run_op(c, a, b, 0, got, das);
      compare_res($sformatf("rnd%0d_op%0d_%h_%h", i, c, a, b), got, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multicycle successor to the processor's combinational ALU. Width is generic.
- Single-cycle ops (add/sub/logic/shift/rotate/not/neg) complete in 1 cycle. MUL and DIV use iterative radix-2 datapaths, shift-add and restoring respectively, so no wide combinational multiplier or divider arrays are needed.
- Sits between the register-file operand latches and the Z-hi/Z-lo result registers. The control FSM stalls on oBusy and captures results on oDone.

Parameters:
- WIDTH, 32: operand and result-half width. Even, ≥4.
- SHW, $clog2(WIDTH): shift/rotate amount width, taken from iB[SHW-1:0].

Ports:
- iClk  in  1  clock, rising edge
- nRst  in  1  asynchronous active-low reset
- iStart  in  1  launch operation. Sampled only when oBusy=0.
- iCtrl  in  4  operation select, existing CTRL_ALU_* encodings (ADD SUB OR XOR AND MUL DIV SLL SRL SRA ROR ROL NOT NEG)
- iA  in  WIDTH  operand A / dividend / shift data
- iB  in  WIDTH  operand B / divisor / shift amount
- oC_hi  out  WIDTH  MUL product high half; DIV remainder; 0 otherwise
- oC_lo  out  WIDTH  result, MUL product low half, or DIV quotient
- oZero  out  1  {oC_hi,oC_lo}==0
- oNeg  out  1  sign flag, rules below
- oOverflow  out  1  signed overflow for ADD/SUB/NEG; 0 otherwise
- oDivZero  out  1  DIV with iB==0
- oBusy  out  1  operation in progress
- oDone  out  1  one-cycle pulse; results valid and held until next iStart

Behaviour:
- Reset (nRst=0, asynchronous): state=IDLE. All outputs, iteration counter and internal registers go to 0. Any operation in progress is abandoned and no oDone is issued.
- Operands and iCtrl are latched at the start edge. Later changes to iA/iB/iCtrl do not affect the operation.
- States: IDLE, ITER, FIX, DONE.
- IDLE, iStart=1, single-cycle op: result registered at the same edge; go to DONE. oDone=1 in cycle 1.
- IDLE, iStart=1, MUL/DIV: latch operand magnitudes (two's-complement abs) and result sign; counter=WIDTH-1; go to ITER. oBusy=1 from cycle 1.
- ITER: one bit per cycle. At counter==0 go to FIX.
  - MUL: 2W-bit accumulator shift-add.
  - DIV: restoring subtract.
- FIX: apply sign correction, register results and flags, then DONE. oDone=1 in cycle WIDTH+2.
- DONE: oDone=1 and oBusy=0 for one cycle, then IDLE. An iStart in DONE is accepted (back-to-back).
- Illegal iCtrl: single-cycle path with result 0, oZero=1.
- iStart while oBusy=1 is ignored and not queued.
- MUL: signed 2W-bit product. oNeg = product bit 2W-1.
- DIV:
  - quotient sign = sign(A)^sign(B), truncating toward zero
  - remainder sign follows dividend
  - oNeg = quotient sign
  - MIN/-1: quotient=MIN, remainder=0, oOverflow=0
- DIV with B=0: no iteration; go directly to FIX (oDone at cycle 2). Results: oDivZero=1, oC_lo=all ones, oC_hi=A, oNeg=0.
- ADD/SUB/NEG:
  - oNeg = true sign of the result (MSB XOR overflow)
  - oOverflow: standard two's-complement overflow
  - NEG = 0-A
- Other single-cycle ops: oNeg = oC_lo[WIDTH-1].
- Shifts/rotates use iB[SHW-1:0]. Amount 0 passes A through. SRA fills with the sign bit.
- oC_hi=0 for all non-MUL/DIV ops. oDivZero=0 except for a DIV with B=0.
- Outputs are held until the next accepted iStart.

Test Plan:
- Reset mid-MUL: start MUL 7×9, pull nRst low at cycle 10 → all outputs 0 and no oDone. Restart ADD 5+3 → oDone at cycle 1, oC_lo=8, oC_hi=0.
- WIDTH=32, MUL -3×0x40000000 → oDone at cycle 34, {hi,lo}=0xFFFFFFFF_40000000, oNeg=1. MUL 0×X → oZero=1.
- DIV -7/2 → quotient -3 (0xFFFFFFFD), remainder -1, oNeg=1. DIV 0x80000000/-1 → quotient 0x80000000, remainder 0. DIV 9/0 → oDone at cycle 2, oDivZero=1, lo=0xFFFFFFFF, hi=9.
- ADD 0x7FFFFFFF+1 → lo=0x80000000, oOverflow=1, oNeg=0. SUB 5-5 → oZero=1. NEG 0x80000000 → oOverflow=1.
- SRA 0x80000000 by 31 → 0xFFFFFFFF. ROL 0x80000001 by 1 → 0x00000003. ROR by 0 → A unchanged. Shift amount from iB=0x21 → 1.
- iStart pulsed during DIV busy → ignored, original result intact. iStart in DONE cycle → new op accepted. Repeat with WIDTH=8: MUL -128×-128 → {hi,lo}=0x4000, done at cycle 10.
